// File: rtl/gray_seq_checker.sv
// rtl/gray_seq_checker.sv - 4-bit reflected Gray sequence checker with lock tracking
// Optional error counter: define GRAY_ERR_CNT_EN to implement ERR_CNT, otherwise it reads 0.
module gray_seq_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VALID,
  input  logic [3:0] GRAY_IN,
  output logic [3:0] BIN,
  output logic       BIN_VALID,
  output logic       LOCKED,
  output logic       ERR,
  output logic       WRAP,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [1:0] {SEARCH, ACQ, LOCK} state_t;

  localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_LIM_W = 4'(MISS_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] last_q, last_d;
  logic [3:0] run_q, run_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] bin_q, bin_d;
  logic       bin_valid_q, bin_valid_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;

  logic [3:0] sample_bin;
  logic       is_repeat;
  logic       is_step;
  logic [3:0] run_inc;
  logic [3:0] miss_inc;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    sample_bin[3] = GRAY_IN[3];
    sample_bin[2] = sample_bin[3] ^ GRAY_IN[2];
    sample_bin[1] = sample_bin[2] ^ GRAY_IN[1];
    sample_bin[0] = sample_bin[1] ^ GRAY_IN[0];
  end

  assign is_repeat = (sample_bin == last_q);
  assign is_step   = (sample_bin == last_q + 4'd1);
  assign run_inc   = (run_q == 4'hF) ? run_q : run_q + 4'd1;
  assign miss_inc  = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= SEARCH;
      last_q      <= 4'd0;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      bin_q       <= 4'd0;
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    run_d       = run_q;
    miss_d      = miss_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    if (VALID) begin
      bin_d       = sample_bin;
      bin_valid_d = 1'b1;
      unique case (state_q)
        SEARCH: begin
          last_d  = sample_bin;
          run_d   = 4'd0;
          state_d = ACQ;
        end
        ACQ: begin
          // A repeated code is a stall and leaves everything untouched.
          if (!is_repeat) begin
            last_d = sample_bin;
            if (is_step) begin
              run_d = run_inc;
              if (run_inc >= LOCK_CNT_W) begin
                state_d = LOCK;
                miss_d  = 4'd0;
              end
            end else begin
              run_d = 4'd0;
            end
          end
        end
        LOCK: begin
          if (!is_repeat) begin
            last_d = sample_bin;
            if (is_step) begin
              miss_d = 4'd0;
              wrap_d = (last_q == 4'hF);
            end else begin
              err_d  = 1'b1;
              miss_d = miss_inc;
              if (miss_inc >= MISS_LIM_W) state_d = SEARCH;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCK);
  end

`ifdef GRAY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 8'd0;
`endif

  assign BIN       = bin_q;
  assign BIN_VALID = bin_valid_q;
  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign WRAP      = wrap_q;

endmodule
